fphub_adder_pipe: RTL and testbench

Pipelined, parametrised HUB-format floating-point adder/subtractor with valid/ready handshaking, a user tag carried alongside each operation, and full one-operation-per-cycle throughput. It is the streaming successor to the combinational HUB adder: same operand format and special-case classes, plus an add/sub opcode, explicit overflow and underflow saturation, and back-pressure. It sits between operand producers (register file or load unit) and result consumers in the HUB FP datapath.

---
 rtl/fphub_adder_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_fphub_adder_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fphub_adder_pipe.sv
// Three-stage HUB floating-point add/sub with valid/ready flow; one op per cycle, whole pipe stalls
// while the output is held. Optional {invalid, overflow, underflow} flags port under FPHUB_ADDER_FLAGS_EN.
module fphub_adder_pipe #(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [E+M:0]     X,
  input  logic [E+M:0]     Y,
  input  logic             op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [E+M:0]     Z,
  output logic [TAG_W-1:0] out_tag
`ifdef FPHUB_ADDER_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  localparam int S  = M + 3;
  localparam int PW = $clog2(S);
  localparam logic [E-1:0] S_E  = E'(S);
  localparam logic [E+M:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  logic advance;
  logic v1_d, v2_d, v3_d, v1_q, v2_q, v3_q;

  logic             sx, sy, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_major;
  logic [E-1:0]     ex, ey, d;
  logic [M-1:0]     mx, my;
  logic [S-1:0]     sig_x, sig_y, min_raw;

  logic             sign1_d, sign1_q, sub1_d, sub1_q, spec1_d, spec1_q;
  logic [E-1:0]     exp1_d, exp1_q;
  logic [S-1:0]     maj1_d, maj1_q, min1_d, min1_q;
  logic [E+M:0]     specz1_d, specz1_q;
  logic [TAG_W-1:0] tag1_d, tag1_q;

  logic             sign2_d, sign2_q, spec2_d, spec2_q;
  logic [E-1:0]     exp2_d, exp2_q;
  logic [S-1:0]     sum2_d, sum2_q;
  logic [PW-1:0]    pos2_d, pos2_q;
  logic [E+M:0]     specz2_d, specz2_q;
  logic [TAG_W-1:0] tag2_d, tag2_q;

  logic [PW-1:0]    sh;
  logic [E+1:0]     exp_n;
  logic [M-1:0]     mant;
  logic [E+M:0]     z_d, z_q;
  logic [TAG_W-1:0] tag3_d, tag3_q;

`ifdef FPHUB_ADDER_FLAGS_EN
  logic       inval1_d, inval1_q, inval2_d, inval2_q;
  logic [2:0] flags_d, flags_q;
`endif

  assign advance   = out_ready | ~v3_q;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign Z         = z_q;
  assign out_tag   = tag3_q;
`ifdef FPHUB_ADDER_FLAGS_EN
  assign flags     = flags_q;
`endif

  assign sx = X[E+M];
  assign sy = Y[E+M] ^ op;
  assign ex = X[E+M-1:M];
  assign ey = Y[E+M-1:M];
  assign mx = X[M-1:0];
  assign my = Y[M-1:0];

  always_comb begin
    v1_d = in_valid;
    v2_d = v1_q;
    v3_d = v2_q;
  end

  // Stage 1: classify, pick the major operand, align the minor one.
  always_comb begin
    x_zero  = (ex == '0);
    y_zero  = (ey == '0);
    x_inf   = (&ex) && (mx == '0);
    y_inf   = (&ey) && (my == '0);
    x_nan   = (&ex) && (mx != '0);
    y_nan   = (&ey) && (my != '0);
    x_major = (ex > ey) || ((ex == ey) && (mx >= my));
    sig_x   = {2'b01, mx, 1'b1};
    sig_y   = {2'b01, my, 1'b1};
    if (x_major) begin
      sign1_d = sx;
      exp1_d  = ex;
      maj1_d  = sig_x;
      min_raw = sig_y;
      d       = ex - ey;
    end else begin
      sign1_d = sy;
      exp1_d  = ey;
      maj1_d  = sig_y;
      min_raw = sig_x;
      d       = ey - ex;
    end
    min1_d   = (d >= S_E) ? '0 : (min_raw >> d);
    sub1_d   = sx ^ sy;
    tag1_d   = in_tag;
    spec1_d  = 1'b1;
    specz1_d = '0;
`ifdef FPHUB_ADDER_FLAGS_EN
    inval1_d = 1'b0;
`endif
    if (x_nan || y_nan) begin
      specz1_d = QNAN;
    end else if (x_inf && y_inf && (sx != sy)) begin
      specz1_d = QNAN;
`ifdef FPHUB_ADDER_FLAGS_EN
      inval1_d = 1'b1;
`endif
    end else if (x_inf) begin
      specz1_d = {sx, X[E+M-1:0]};
    end else if (y_inf) begin
      specz1_d = {sy, Y[E+M-1:0]};
    end else if (x_zero && y_zero) begin
      specz1_d = {sx & sy, {(E+M){1'b0}}};
    end else if (x_zero) begin
      specz1_d = {sy, Y[E+M-1:0]};
    end else if (y_zero) begin
      specz1_d = X;
    end else begin
      spec1_d = 1'b0;
    end
  end

  // Stage 2: add or subtract aligned significands and locate the leading one.
  always_comb begin
    sum2_d   = sub1_q ? (maj1_q - min1_q) : (maj1_q + min1_q);
    pos2_d   = '0;
    for (int i = 0; i < S; i++) begin
      if (sum2_d[i]) pos2_d = PW'(i);
    end
    sign2_d  = sign1_q;
    exp2_d   = exp1_q;
    spec2_d  = spec1_q;
    specz2_d = specz1_q;
    tag2_d   = tag1_q;
`ifdef FPHUB_ADDER_FLAGS_EN
    inval2_d = inval1_q;
`endif
  end

  // Stage 3: normalise, truncate (HUB rounding), saturate and pack.
  always_comb begin
    sh     = PW'(M + 1) - pos2_q;
    tag3_d = tag2_q;
    if (sum2_q[S-1]) begin
      exp_n = {2'b00, exp2_q} + (E+2)'(1);
      mant  = sum2_q[S-2:2];
    end else begin
      exp_n = {2'b00, exp2_q} - (E+2)'(sh);
      mant  = M'((sum2_q << sh) >> 1);
    end
`ifdef FPHUB_ADDER_FLAGS_EN
    flags_d = {inval2_q, 2'b00};
`endif
    if (spec2_q) begin
      z_d = specz2_q;
    end else if (sum2_q == '0) begin
      z_d = '0;
    end else if (!exp_n[E+1] && (exp_n[E] || (&exp_n[E-1:0]))) begin
      z_d = {sign2_q, {E{1'b1}}, {M{1'b0}}};
`ifdef FPHUB_ADDER_FLAGS_EN
      flags_d[1] = 1'b1;
`endif
    end else if (exp_n[E+1] || (exp_n == '0)) begin
      z_d = {sign2_q, {(E+M){1'b0}}};
`ifdef FPHUB_ADDER_FLAGS_EN
      flags_d[0] = 1'b1;
`endif
    end else begin
      z_d = {sign2_q, exp_n[E-1:0], mant};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      z_q     <= '0;
      tag3_q  <= '0;
`ifdef FPHUB_ADDER_FLAGS_EN
      flags_q <= '0;
`endif
    end else if (advance) begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      z_q     <= z_d;
      tag3_q  <= tag3_d;
`ifdef FPHUB_ADDER_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sign1_q  <= sign1_d;
      sub1_q   <= sub1_d;
      spec1_q  <= spec1_d;
      exp1_q   <= exp1_d;
      maj1_q   <= maj1_d;
      min1_q   <= min1_d;
      specz1_q <= specz1_d;
      tag1_q   <= tag1_d;
      sign2_q  <= sign2_d;
      spec2_q  <= spec2_d;
      exp2_q   <= exp2_d;
      sum2_q   <= sum2_d;
      pos2_q   <= pos2_d;
      specz2_q <= specz2_d;
      tag2_q   <= tag2_d;
`ifdef FPHUB_ADDER_FLAGS_EN
      inval1_q <= inval1_d;
      inval2_q <= inval2_d;
`endif
    end
  end

endmodule

// File: tb/tb_fphub_adder_pipe.sv
// Directed-vector bench for fphub_adder_pipe (M=23, E=8): latency, results, stall and reset behaviour.
module tb_fphub_adder_pipe;
  localparam int M = 23;
  localparam int E = 8;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, op, out_valid, out_ready;
  logic [E+M:0]     X, Y, Z;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef FPHUB_ADDER_FLAGS_EN
  logic [2:0]       flags;
`endif

  always #5 clk = ~clk;

  fphub_adder_pipe #(.M(M), .E(E), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .Z(Z), .out_tag(out_tag)
`ifdef FPHUB_ADDER_FLAGS_EN
    , .flags(flags)
`endif
  );

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        op;
    logic [3:0]  tag;
    logic [31:0] z;
    logic [2:0]  fl;
  } vec_t;

  vec_t vt [14];
  int   sidx [5];
  int   errors = 0;
  int   checks = 0;
  int   lat, pushed, popped, extra;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [3:0] tag);
    X      = v.x;
    Y      = v.y;
    op     = v.op;
    in_tag = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //         X             Y             op    tag    Z             {inv,ovf,unf}
    vt[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 4'h1, 32'h40000000, 3'b000};
    vt[1]  = '{32'h3FC00000, 32'h3F800000, 1'b1, 4'h2, 32'h3F000000, 3'b000};
    vt[2]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 4'h3, 32'h00000000, 3'b000};
    vt[3]  = '{32'h7F800000, 32'h3F800000, 1'b0, 4'h4, 32'h7F800000, 3'b000};
    vt[4]  = '{32'h7F800000, 32'hFF800000, 1'b0, 4'h5, 32'h7FC00000, 3'b100};
    vt[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'h6, 32'h7F800000, 3'b010};
    vt[6]  = '{32'h00800001, 32'h80800000, 1'b0, 4'h7, 32'h00000000, 3'b001};
    // Major operand is the negative one here, so the flushed zero is negative.
    vt[7]  = '{32'h00800000, 32'h80800001, 1'b0, 4'h8, 32'h80000000, 3'b001};
    vt[8]  = '{32'h00000000, 32'h3F800000, 1'b1, 4'h9, 32'hBF800000, 3'b000};
    vt[9]  = '{32'h80000000, 32'h80000000, 1'b0, 4'hA, 32'h80000000, 3'b000};
    vt[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 4'hB, 32'h7FC00000, 3'b000};
    vt[11] = '{32'h3F800000, 32'h3F000000, 1'b0, 4'hC, 32'h3FC00000, 3'b000};
    // Dropped minor ILSB leaves a trailing one after renormalising.
    vt[12] = '{32'h40000000, 32'h3F800000, 1'b1, 4'hD, 32'h3F800001, 3'b000};
    vt[13] = '{32'h4B800000, 32'h3F800000, 1'b0, 4'hE, 32'h4B800001, 3'b000};
    sidx[0] = 0; sidx[1] = 1; sidx[2] = 11; sidx[3] = 12; sidx[4] = 13;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    X = '0; Y = '0; op = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset Z", Z, 32'h0);
    check("reset out_tag", 32'(out_tag), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
`ifdef FPHUB_ADDER_FLAGS_EN
    check("reset flags", 32'(flags), 32'd0);
`endif

    // Single operations: latency, result and tag for each vector.
    for (int i = 0; i < 14; i++) begin
      drive(vt[i], vt[i].tag);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("latency[%0d]", i), 32'(lat), 32'd3);
      check($sformatf("Z[%0d]", i), Z, vt[i].z);
      check($sformatf("tag[%0d]", i), 32'(out_tag), 32'(vt[i].tag));
`ifdef FPHUB_ADDER_FLAGS_EN
      check($sformatf("flags[%0d]", i), 32'(flags), 32'(vt[i].fl));
`endif
      @(posedge clk); #1;
    end

    // Streaming with a 4-cycle output stall.
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 40 && popped < 5; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 8);
      in_valid  = (pushed < 5);
      if (pushed < 5) drive(vt[sidx[pushed]], 4'(pushed + 1));
      #1;
      if (cyc >= 4 && cyc < 8) begin
        check($sformatf("stall in_ready c%0d", cyc), 32'(in_ready), 32'd0);
        check($sformatf("stall out_valid c%0d", cyc), 32'(out_valid), 32'd1);
        check($sformatf("stall Z c%0d", cyc), Z, vt[sidx[popped]].z);
        check($sformatf("stall tag c%0d", cyc), 32'(out_tag), 32'(popped + 1));
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream Z %0d", popped), Z, vt[sidx[popped]].z);
        check($sformatf("stream tag %0d", popped), 32'(out_tag), 32'(popped + 1));
        popped++;
      end
      if (in_valid && in_ready) pushed++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream count", 32'(popped), 32'd5);
    extra = 0;
    repeat (5) begin
      #1;
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    check("stream no duplicates", 32'(extra), 32'd0);

    // Reset with two operations in flight.
    for (int k = 0; k < 2; k++) begin
      drive(vt[k], 4'(k + 8));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midreset Z", Z, 32'h0);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    extra = 0;
    repeat (6) begin
      if (out_valid) extra++;
      @(posedge clk); #2;
    end
    check("midreset no output", 32'(extra), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
